// File: rtl/timer.sv
// Programmable 32-bit down-counter with one-shot / auto-reload modes and a
// level interrupt, accessed through a 2-bit word-select register port.
module timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [31:0] WD,
    input  logic        We,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq;

    logic [31:0] w_count_next;
    logic        w_en_clr;
    logic        w_irq_set;
    logic        w_irq_pulse_end;
    logic        w_ctrl_we;
    logic        w_preset_we;
    logic        w_auto;

    assign w_ctrl_we   = We && (addr == 2'd0);
    assign w_preset_we = We && (addr == 2'd1);
    assign w_auto      = (r_mode == 2'd1);

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_en_clr        = 1'b0;
        w_irq_set       = 1'b0;
        w_irq_pulse_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_next = r_preset;
                w_state_next = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_next = S_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_next = r_count - 32'd1;
                end else begin
                    // Covers both COUNT==1 and COUNT==0; never wraps below zero.
                    w_count_next = '0;
                    w_state_next = S_INT;
                    w_irq_set    = 1'b1;
                end
            end
            S_INT: begin
                if (w_auto) begin
                    w_state_next    = S_LOAD;
                    w_irq_pulse_end = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                    w_en_clr     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_mode   <= '0;
            r_im     <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            // A CTRL write takes priority over the one-shot self-disable.
            if (w_ctrl_we) begin
                {r_im, r_mode, r_en} <= WD[3:0];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end

            if (w_preset_we) begin
                r_preset <= WD;
            end

            // Setting the flag wins over a same-edge CTRL write clearing it.
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (w_irq_pulse_end || w_ctrl_we) begin
                r_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        RD = '0;
        case (addr)
            2'd0:    RD = {28'b0, r_im, r_mode, r_en};
            2'd1:    RD = r_preset;
            2'd2:    RD = r_count;
            default: RD = '0;
        endcase
    end

    assign IRQ = r_irq & r_im;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized runs
// compared against a closed-form timing model of the counter.
module tb_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [31:0] WD;
    logic        We;
    logic [31:0] RD;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    timer dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WD    (WD),
        .We    (We),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        WD   = d;
        We   = 1'b1;
        tick();
        We   = 1'b0;
        addr = 2'd2;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = RD;
    endtask

    task automatic do_reset();
        We    = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Model: enable written at cycle 0 with PRESET=n. L = cycles spent
    // counting before expiry, expiry at cycle 2+L, reload period L+2.
    task automatic run_check(input int n, input bit auto_m, input logic [1:0] mode,
                             input bit im0, input bit im1, input int sw, input int ncyc,
                             input string name);
        int          L, E, P, k, v;
        bit          im, exp_irq, exp_en;
        logic [31:0] exp_cnt, exp_ctrl, got;
        L = (n == 0) ? 1 : n;
        E = 2 + L;
        P = L + 2;
        do_reset();
        wr(2'd1, 32'(n));
        wr(2'd0, {28'b0, im0, mode, 1'b1});
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                if (c == sw) wr(2'd0, {28'b0, im1, mode, 1'b1});
                else tick();
            end
            im = (c >= sw) ? im1 : im0;
            if (c < 2) begin
                exp_cnt = '0;
                exp_irq = 1'b0;
                exp_en  = 1'b1;
            end else if (!auto_m) begin
                v       = n - (c - 2);
                exp_cnt = (v > 0) ? 32'(v) : 32'd0;
                exp_irq = (c >= E);
                exp_en  = (c <= E);
            end else begin
                k       = (c - 2) % P;
                v       = n - k;
                exp_cnt = (k <= L && v > 0) ? 32'(v) : 32'd0;
                exp_irq = (k == L);
                exp_en  = 1'b1;
            end
            exp_ctrl = {28'b0, im, mode, exp_en};
            rd(2'd2, got);
            checks++;
            if (got !== exp_cnt) begin
                failures++;
                $display("FAIL %s count c=%0d: got %0d required %0d", name, c, got, exp_cnt);
            end
            checks++;
            if (IRQ !== (exp_irq & im)) begin
                failures++;
                $display("FAIL %s irq c=%0d: got %b required %b", name, c, IRQ, exp_irq & im);
            end
            rd(2'd0, got);
            checks++;
            if (got !== exp_ctrl) begin
                failures++;
                $display("FAIL %s ctrl c=%0d: got %h required %h", name, c, got, exp_ctrl);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] got;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), got);
            checks++;
            if (got !== 32'd0) begin
                failures++;
                $display("FAIL %s rd addr=%0d: got %h required 0", name, a, got);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL %s irq: got %b required 0", name, IRQ);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        do_reset();
        check_all_zero("reset");
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, got);
        checks++;
        if (got !== 32'd0) begin
            failures++;
            $display("FAIL count_write_ignored: got %h required 0", got);
        end
        check_all_zero("reset_after_ignored_writes");
    endtask

    task automatic test_oneshot();
        run_check(5, 1'b0, 2'd0, 1'b1, 1'b1, 1000, 12, "oneshot");
        checks++;
        if (IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_hold: got %b required 1", IRQ);
        end
        wr(2'd0, 32'h0);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_clear: got %b required 0", IRQ);
        end
        wr(2'd0, 32'h8);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_flag_cleared: got %b required 0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        run_check(3, 1'b1, 2'd1, 1'b1, 1'b1, 1000, 22, "autoreload");
    endtask

    task automatic test_masked();
        run_check(3, 1'b1, 2'd1, 1'b0, 1'b1, 13, 26, "masked");
    endtask

    task automatic test_preset_zero();
        run_check(0, 1'b0, 2'd2, 1'b1, 1'b1, 1000, 6, "preset_zero");
    endtask

    task automatic test_disable();
        logic [31:0] got;
        bit          found;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd(2'd2, got);
            if (got == 32'd6) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL disable_reach6: got %0d required 6", got);
        end
        wr(2'd0, 32'h8);
        for (int i = 0; i < 5; i++) begin
            rd(2'd2, got);
            checks++;
            if (got !== 32'd5) begin
                failures++;
                $display("FAIL disable_frozen i=%0d: got %0d required 5", i, got);
            end
            tick();
        end
        wr(2'd0, 32'h9);
        tick();
        rd(2'd2, got);
        checks++;
        if (got !== 32'd5) begin
            failures++;
            $display("FAIL reenable_load_cycle: got %0d required 5", got);
        end
        tick();
        rd(2'd2, got);
        checks++;
        if (got !== 32'd10) begin
            failures++;
            $display("FAIL reenable_reload: got %0d required 10", got);
        end
        tick();
        wr(2'd1, 32'd3);
        rd(2'd2, got);
        checks++;
        if (got !== 32'd8) begin
            failures++;
            $display("FAIL preset_write_no_effect: got %0d required 8", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        do_reset();
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rd(2'd2, got);
        checks++;
        if (got !== 32'd17) begin
            failures++;
            $display("FAIL reset_mid_precount: got %0d required 17", got);
        end
        do_reset();
        check_all_zero("reset_mid_count");
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        checks++;
        if (IRQ !== 1'b1) begin
            failures++;
            $display("FAIL reset_irq_pre: got %b required 1", IRQ);
        end
        do_reset();
        check_all_zero("reset_with_irq");
    endtask

    task automatic test_simultaneous();
        logic [31:0] got;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        repeat (3) tick();
        wr(2'd0, 32'h9);
        checks++;
        if (IRQ !== 1'b1) begin
            failures++;
            $display("FAIL sim_set_wins: got %b required 1", IRQ);
        end
        tick();
        rd(2'd0, got);
        checks++;
        if (got !== 32'h8 || IRQ !== 1'b1) begin
            failures++;
            $display("FAIL sim_oneshot_done: got ctrl=%h irq=%b required ctrl=8 irq=1", got, IRQ);
        end

        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        wr(2'd0, 32'h9);
        rd(2'd0, got);
        checks++;
        if (got !== 32'h9 || IRQ !== 1'b0) begin
            failures++;
            $display("FAIL sim_write_wins: got ctrl=%h irq=%b required ctrl=9 irq=0", got, IRQ);
        end
        repeat (2) tick();
        rd(2'd2, got);
        checks++;
        if (got !== 32'd2) begin
            failures++;
            $display("FAIL sim_restart: got %0d required 2", got);
        end
    endtask

    task automatic test_random();
        int         n, sw, ncyc;
        bit         auto_m, im0, im1;
        logic [1:0] mode;
        logic [1:0] oneshot_modes [3];
        oneshot_modes[0] = 2'd0;
        oneshot_modes[1] = 2'd2;
        oneshot_modes[2] = 2'd3;
        for (int t = 0; t < 10; t++) begin
            n      = $urandom_range(0, 6);
            auto_m = 1'($urandom_range(0, 1));
            im0    = 1'($urandom_range(0, 1));
            im1    = 1'($urandom_range(0, 1));
            mode   = auto_m ? 2'd1 : oneshot_modes[$urandom_range(0, 2)];
            sw     = auto_m ? $urandom_range(1, 20) : 1000;
            ncyc   = 2 * (n + 3) + 6;
            run_check(n, auto_m, mode, im0, im1, sw, ncyc, "random");
        end
    endtask

    initial begin
        reset = 1'b0;
        addr  = 2'd0;
        WD    = '0;
        We    = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_preset_zero();
        test_disable();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
